// File: rtl/key_frame_rx_pkg.sv
// Shared key-frame format: sync marker, payload length, state codes and checksum rule.
// The sender imports this same package so both ends agree on the frame layout.
package key_frame_rx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         NUM_BYTES = 5;
    localparam int         KEY_W     = 8 * NUM_BYTES;

    typedef enum logic [3:0] {
        HUNT    = 4'd0,
        PAYLOAD = 4'd1,
        CHECK   = 4'd2,
        COMMIT  = 4'd3
    } sta_e;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Checksum byte that follows the payload: XOR of all payload bytes.
    function automatic logic [7:0] frame_csum(input logic [KEY_W-1:0] keys);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            acc = csum_step(acc, keys[8*i +: 8]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_frame_rx_if.sv
// UART-side byte input and key-frame results of the receiver.
interface key_frame_rx_if;
    import key_frame_rx_pkg::*;

    logic             read_done;
    logic [7:0]       read_data;
    logic [KEY_W-1:0] key_down;
    logic             frame_valid;
    logic [7:0]       err_cnt;
    logic [3:0]       sta;

    modport master (
        output read_done, read_data,
        input  key_down, frame_valid, err_cnt, sta
    );

    modport slave (
        input  read_done, read_data,
        output key_down, frame_valid, err_cnt, sta
    );
endinterface

// File: rtl/key_frame_rx_edge_pulse.sv
// Rising-edge detector: one-cycle pulse on the cycle a level flag goes high.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic in_level,
    output logic out_pulse
);
    logic level_q, level_d;

    always_comb begin
        level_d = in_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign out_pulse = in_level & ~level_q;
endmodule

// File: rtl/key_frame_rx.sv
// Key-frame receiver: SYNC, NUM_BYTES payload bytes, XOR checksum; commits the
// payload to key_down only when the whole frame checks out.
module key_frame_rx
    import key_frame_rx_pkg::*;
#(
    parameter int TIMEOUT = 24000,
    parameter int TW      = 15
) (
    input  logic          clk,
    input  logic          rst,
    key_frame_rx_if.slave bus
);
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    sta_e             state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       acc_q, acc_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       err_q, err_d;
    logic [KEY_W-1:0] sh_q, sh_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             fv_q, fv_d;
    logic             stb;
    logic             expire;

    edge_pulse u_edge (
        .clk      (clk),
        .rst      (rst),
        .in_level (bus.read_done),
        .out_pulse(stb)
    );

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign expire = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        timer_d = timer_q;
        err_d   = err_q;
        sh_d    = sh_q;
        key_d   = key_q;
        fv_d    = 1'b0;
        case (state_q)
            HUNT: begin
                if (stb && bus.read_data == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    acc_d   = '0;
                    timer_d = '0;
                end
            end
            PAYLOAD: begin
                if (stb) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (idx_q == IW'(i)) sh_d[8*i +: 8] = bus.read_data;
                    end
                    acc_d   = csum_step(acc_q, bus.read_data);
                    timer_d = '0;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(NUM_BYTES - 1)) state_d = CHECK;
                end else if (expire) begin
                    err_d   = sat_inc(err_q);
                    state_d = HUNT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (stb) begin
                    timer_d = '0;
                    if (bus.read_data == acc_q) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = sat_inc(err_q);
                        state_d = HUNT;
                    end
                end else if (expire) begin
                    err_d   = sat_inc(err_q);
                    state_d = HUNT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            COMMIT: begin
                // Any byte strobed in this cycle is dropped; frames are spaced apart.
                key_d   = sh_q;
                fv_d    = 1'b1;
                state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            idx_q   <= '0;
            acc_q   <= '0;
            timer_q <= '0;
            err_q   <= '0;
            key_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            key_q   <= key_d;
            fv_q    <= fv_d;
        end
    end

    // Staging register is fully rewritten before every commit, so it needs no reset.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign bus.key_down    = key_q;
    assign bus.frame_valid = fv_q;
    assign bus.err_cnt     = err_q;
    assign bus.sta         = state_q;
endmodule

// File: tb/tb_key_frame_rx.sv
// Bench for key_frame_rx: frame table, timeout/reset/saturation sequences and a
// randomized byte stream checked against a frame-level reference model.
module tb_key_frame_rx;
    import key_frame_rx_pkg::*;

    localparam int TO = 24000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_stb = 0;
    int   fv_seen  = 0;

    key_frame_rx_if bus ();

    key_frame_rx #(.TIMEOUT(TO), .TW(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: whole frames collected in a queue, judged once complete.
    typedef struct {
        int               cyc;
        logic [KEY_W-1:0] key;
    } fv_exp_t;

    fv_exp_t          exp_fv_q[$];
    logic [7:0]       m_buf[$];
    bit               m_in_frame = 0;
    int               m_last     = 0;
    logic [7:0]       m_err      = 8'h00;
    logic [KEY_W-1:0] m_key      = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_err      = 8'h00;
        m_key      = '0;
        m_buf.delete();
        exp_fv_q.delete();
    endtask

    task automatic model_timeout(input int now);
        if (m_in_frame && now >= m_last + TO) begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            m_in_frame = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int s);
        logic [7:0]       x;
        logic [KEY_W-1:0] k;
        model_timeout(s - 1);
        if (!m_in_frame) begin
            if (b == SYNC_BYTE) begin
                m_in_frame = 1;
                m_buf.delete();
                m_last = s;
            end
        end else begin
            m_buf.push_back(b);
            m_last = s;
            if (m_buf.size() == NUM_BYTES + 1) begin
                x = 8'h00;
                k = '0;
                for (int i = 0; i < NUM_BYTES; i++) begin
                    x = x ^ m_buf[i];
                    k[8*i +: 8] = m_buf[i];
                end
                if (x == m_buf[NUM_BYTES]) begin
                    m_key = k;
                    exp_fv_q.push_back('{s + 1, k});
                end else if (m_err != 8'hFF) begin
                    m_err = m_err + 8'd1;
                end
                m_in_frame = 0;
            end
        end
    endtask

    // frame_valid must be high exactly on the cycles the model predicts.
    always @(negedge clk) begin
        bit exp_now;
        if (!rst) begin
            exp_now = (exp_fv_q.size() > 0) && (exp_fv_q[0].cyc == cyc);
            if (bus.frame_valid) fv_seen++;
            if (exp_now || bus.frame_valid) begin
                chk("frame_valid", 64'(bus.frame_valid), 64'(exp_now));
                if (exp_now) begin
                    chk("key_at_pulse", 64'(bus.key_down), 64'(exp_fv_q[0].key));
                    void'(exp_fv_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1 with read_done low; the strobe lands on the next edge.
    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        int s;
        s = cyc + 1;
        model_byte(b, s);
        bus.read_data = b;
        bus.read_done = 1'b1;
        last_stb = s;
        idle(hi);
        bus.read_done = 1'b0;
        idle(lo);
    endtask

    task automatic send_seq(input logic [6:0][7:0] seq, input int nb, input int hi, input int lo);
        for (int j = 0; j < nb; j++) send_byte(seq[6-j], hi, lo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_frame();
        int         kind, hi, lo, drop, n;
        logic [7:0] pl[NUM_BYTES];
        logic [7:0] cs;
        kind = $urandom_range(0, 9);
        hi   = $urandom_range(1, 4);
        lo   = $urandom_range(1, 4);
        if (kind == 2) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 164)), hi, lo);
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            pl[i] = ($urandom_range(0, 3) == 0) ? SYNC_BYTE : 8'($urandom);
            cs = cs ^ pl[i];
        end
        if (kind < 2) cs = cs ^ 8'($urandom_range(1, 255));
        drop = (kind == 3) ? $urandom_range(0, NUM_BYTES) : -1;
        send_byte(SYNC_BYTE, hi, lo);
        for (int i = 0; i < NUM_BYTES; i++) if (i != drop) send_byte(pl[i], hi, lo);
        if (drop != NUM_BYTES) send_byte(cs, hi, lo);
    endtask

    typedef struct {
        logic [6:0][7:0]  seq;
        int               nb;
        int               hi;
        logic [KEY_W-1:0] key;
        logic [7:0]       err;
        logic [3:0]       sta;
        int               fv;
    } vec_t;

    vec_t vt[8];

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int L, fv0;
        vt[0] = '{56'hA5_01_02_04_08_10_1F, 7, 1,  40'h10_08_04_02_01, 8'd0, 4'd0, 1};
        vt[1] = '{56'hA5_FF_00_00_00_00_00, 7, 2,  40'h10_08_04_02_01, 8'd1, 4'd0, 0};
        vt[2] = '{56'hA5_01_02_04_08_10_1F, 7, 3,  40'h10_08_04_02_01, 8'd1, 4'd0, 1};
        vt[3] = '{56'hA5_A5_A5_00_00_00_00, 7, 1,  40'h00_00_00_A5_A5, 8'd1, 4'd0, 1};
        vt[4] = '{56'h00_33_7F_00_00_00_00, 3, 1,  40'h00_00_00_A5_A5, 8'd1, 4'd0, 0};
        vt[5] = '{56'h00_00_00_00_00_00_00, 1, 10, 40'h00_00_00_A5_A5, 8'd1, 4'd0, 0};
        vt[6] = '{56'hA5_80_40_20_10_08_F8, 7, 10, 40'h08_10_20_40_80, 8'd1, 4'd0, 1};
        vt[7] = '{56'hA5_11_22_00_00_00_00, 3, 2,  40'h08_10_20_40_80, 8'd1, 4'd1, 0};

        bus.read_done = 1'b0;
        bus.read_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_key", 64'(bus.key_down), 64'h0);
        chk("reset_fv", 64'(bus.frame_valid), 64'h0);
        chk("reset_err", 64'(bus.err_cnt), 64'h0);
        chk("reset_sta", 64'(bus.sta), 64'h0);

        for (int v = 0; v < 8; v++) begin
            fv0 = fv_seen;
            send_seq(vt[v].seq, vt[v].nb, vt[v].hi, 1);
            idle(3);
            chk($sformatf("vec%0d_key", v), 64'(bus.key_down), 64'(vt[v].key));
            chk($sformatf("vec%0d_err", v), 64'(bus.err_cnt), 64'(vt[v].err));
            chk($sformatf("vec%0d_sta", v), 64'(bus.sta), 64'(vt[v].sta));
            chk($sformatf("vec%0d_fvcount", v), 64'(fv_seen - fv0), 64'(vt[v].fv));
        end

        // Byte arriving exactly at timer expiry wins; a longer gap times out.
        L = last_stb;
        wait_to(L + TO - 1);
        chk("pre_expiry_sta", 64'(bus.sta), 64'd1);
        send_byte(8'h33, 1, 1);
        chk("byte_wins_sta", 64'(bus.sta), 64'd1);
        chk("byte_wins_err", 64'(bus.err_cnt), 64'd1);
        L = last_stb;
        wait_to(L + TO - 1);
        chk("timeout_edge_minus1_sta", 64'(bus.sta), 64'd1);
        chk("timeout_edge_minus1_err", 64'(bus.err_cnt), 64'd1);
        wait_to(L + TO);
        model_timeout(cyc);
        chk("timeout_sta", 64'(bus.sta), 64'd0);
        chk("timeout_err", 64'(bus.err_cnt), 64'd2);
        chk("timeout_err_model", 64'(bus.err_cnt), 64'(m_err));
        send_seq(vt[0].seq, 7, 1, 1);
        idle(3);
        chk("after_timeout_key", 64'(bus.key_down), 64'h10_08_04_02_01);
        chk("after_timeout_err", 64'(bus.err_cnt), 64'd2);

        // Reset in the middle of a frame.
        send_seq(56'hA5_01_02_03_00_00_00, 4, 1, 1);
        chk("midframe_sta", 64'(bus.sta), 64'd1);
        do_reset();
        chk("midreset_key", 64'(bus.key_down), 64'h0);
        chk("midreset_err", 64'(bus.err_cnt), 64'h0);
        chk("midreset_sta", 64'(bus.sta), 64'h0);
        chk("midreset_fv", 64'(bus.frame_valid), 64'h0);
        fv0 = fv_seen;
        send_seq(vt[0].seq, 7, 1, 1);
        idle(3);
        chk("post_reset_key", 64'(bus.key_down), 64'h10_08_04_02_01);
        chk("post_reset_err", 64'(bus.err_cnt), 64'h0);
        chk("post_reset_fvcount", 64'(fv_seen - fv0), 64'd1);

        for (int f = 0; f < 60; f++) begin
            rand_frame();
            idle(3);
            chk($sformatf("rand%0d_err", f), 64'(bus.err_cnt), 64'(m_err));
            chk($sformatf("rand%0d_key", f), 64'(bus.key_down), 64'(m_key));
        end

        // Error counter saturation.
        do_reset();
        for (int f = 0; f < 300; f++) send_seq(56'hA5_00_00_00_00_00_01, 7, 1, 1);
        idle(3);
        chk("sat_err", 64'(bus.err_cnt), 64'hFF);
        chk("sat_err_model", 64'(bus.err_cnt), 64'(m_err));
        chk("sat_key_held", 64'(bus.key_down), 64'h0);
        send_seq(vt[6].seq, 7, 1, 1);
        idle(3);
        chk("sat_good_key", 64'(bus.key_down), 64'h08_10_20_40_80);
        chk("sat_good_err", 64'(bus.err_cnt), 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_frame_rx.md
Name: key_frame_rx

Overview:
- Receive-side counterpart of the key-state UART sender.
- Consumes bytes from the uart receiver (read_data / read_done) and parses fixed-length key frames: sync byte, 5 payload bytes, XOR checksum.
- Each valid frame updates a held 40-bit key_down vector and pulses frame_valid.
- Used for PC/board-to-board loopback and for driving ui key highlighting from a remote source.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
NUM_BYTES, 5, payload bytes per frame; key vector width = 8*NUM_BYTES
TIMEOUT, 24000, max clk cycles between bytes inside a frame (1 ms at 24 MHz)
TW, 15, width of inter-byte timer (must hold TIMEOUT)

Ports:
clk  in  1  system clock (clk24 domain)
rst  in  1  reset; synchronous, active-high
read_done  in  1  uart byte-received flag, level, synchronous to clk; a new byte is signalled by its rising edge
read_data  in  8  received byte, stable while read_done high
key_down  out  8*NUM_BYTES  last accepted key vector, held between frames
frame_valid  out  1  one-cycle pulse when key_down is updated
err_cnt  out  8  saturating count of rejected frames
sta  out  4  current FSM state code, for 7-seg debug

Behaviour:
- Reset (rst=1 at a clk edge): key_down=0, frame_valid=0, err_cnt=0, sta=HUNT(0), edge register=0, timer=0, byte index=0, checksum accumulator=0. Reset mid-frame discards the partial frame with no error count.
- Byte strobe: stb = read_done & ~read_done_q, where read_done_q is registered read_done. read_data is sampled in the stb cycle.
- States (sta encoding): HUNT=0, PAYLOAD=1, CHECK=2, COMMIT=3.
- HUNT:
  - On stb with read_data==SYNC_BYTE: go to PAYLOAD; idx=0, acc=0, timer=0.
  - Other bytes are ignored silently, with no error count.
- PAYLOAD:
  - On stb: shift register slot idx <= read_data (byte 0 = key bits [7:0], LSB-first byte order); acc ^= read_data; timer=0; idx++.
  - When idx reaches NUM_BYTES-1 on that stb, go to CHECK.
  - A SYNC_BYTE value here is treated as data.
- CHECK:
  - On stb: if read_data==acc, go to COMMIT; else err_cnt++ (saturating) and go to HUNT.
- COMMIT (one cycle):
  - key_down <= shift register.
  - frame_valid=1 in the same cycle key_down changes, i.e. 2 clk after the checksum byte's read_done rise.
  - Then go to HUNT.
- Timeout:
  - In PAYLOAD and CHECK, timer increments each cycle without stb.
  - When timer==TIMEOUT-1 and no stb this cycle: err_cnt++ (saturating), go to HUNT, timer=0.
  - If stb and expiry coincide, the byte wins and the timer clears.
  - No timer in HUNT or COMMIT.
- err_cnt saturates at 8'hFF; it is not cleared by good frames.
- key_down is never partially updated; a rejected frame leaves the previous value intact.
- A stb arriving during COMMIT is dropped. The sender guarantees ≥1 byte time between frames, so this is benign.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package/header holds: SYNC_BYTE, NUM_BYTES, the sta codes (HUNT/PAYLOAD/CHECK/COMMIT) and the frame checksum rule. The sender side includes the same package so the frame format is single-sourced.
- One natural sub-module: edge_pulse (registered rising-edge detector: in, out one-cycle pulse, clk, rst), reused for other flag-level handshakes in the design.

Test Plan:
- Good frame A5,01,02,04,08,10,checksum 1F → key_down=40'h10_08_04_02_01, frame_valid high exactly 1 cycle, 2 clk after last read_done rise, err_cnt=0.
- Bad checksum A5,FF,00,00,00,00,00 → key_down unchanged, no frame_valid, err_cnt=1, sta back to 0; a following good frame is accepted.
- Sync inside payload A5,A5,A5,00,00,00,checksum 00 → accepted, key_down=40'h00_00_00_A5_A5.
- Timeout: A5,11, then idle TIMEOUT cycles → err_cnt+1, sta=0; a later A5 starts a fresh frame.
- Noise bytes 00,33,7F in HUNT → no error, no state change. Holding read_done high across 10 cycles counts as one byte only.
- Reset asserted after 3 payload bytes; after release send a good frame → err_cnt=0, the frame is accepted normally. Also drive 300 bad frames → err_cnt holds at FF.
